param_counter_with_checks: RTL



---
 rtl/param_counter_with_checks.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/param_counter_with_checks.sv
// Parametrised wrap-round counter with IDLE/RUN/DONE run control and wrap/completion messages.
// Optional immediate-assertion checker enabled by defining PARAM_COUNTER_CHECK_EN.
module param_counter_with_checks #(
  parameter int WIDTH  = 4,
  parameter int LIMIT  = 9,
  parameter int ROUNDS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic [7:0]       wraps,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] LIMIT_C  = WIDTH'(LIMIT);
  localparam logic [7:0]       ROUNDS_C = 8'(ROUNDS);

  // Illegal configurations stop elaboration rather than producing a silently wrong counter.
  if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
    $error("param_counter_with_checks: WIDTH %0d outside 2..16", WIDTH);
  end
  if (LIMIT < 1 || LIMIT > (1 << WIDTH) - 1) begin : g_bad_limit
    $error("param_counter_with_checks: LIMIT %0d outside 1..2**WIDTH-1", LIMIT);
  end
  if (ROUNDS < 1 || ROUNDS > 255) begin : g_bad_rounds
    $error("param_counter_with_checks: ROUNDS %0d outside 1..255", ROUNDS);
  end

  state_t           state_r;
  logic [WIDTH-1:0] count_r;
  logic             tc_r;
  logic [7:0]       wraps_r;
  logic             busy_r;
  logic             done_r;

  logic [WIDTH-1:0] step_s;
  logic             wrap_s;
  logic [WIDTH-1:0] clip_s;
  logic [WIDTH-1:0] start_val_s;
  logic [7:0]       wraps_inc_s;

  // Next count for an enabled step in the live direction, and whether that step wraps.
  always_comb begin
    step_s = count_r;
    wrap_s = 1'b0;
    if (dir) begin
      if (count_r == WIDTH'(0)) begin
        step_s = LIMIT_C;
        wrap_s = 1'b1;
      end else begin
        step_s = count_r - WIDTH'(1);
      end
    end else begin
      if (count_r == LIMIT_C) begin
        step_s = WIDTH'(0);
        wrap_s = 1'b1;
      end else begin
        step_s = count_r + WIDTH'(1);
      end
    end
  end

  // Load value clipped to the terminal count, run start value, and saturating wrap counter.
  always_comb begin
    clip_s      = load_val;
    start_val_s = WIDTH'(0);
    wraps_inc_s = wraps_r;
    if (load_val > LIMIT_C) begin
      clip_s = LIMIT_C;
    end else begin
      clip_s = load_val;
    end
    if (dir) begin
      start_val_s = LIMIT_C;
    end else begin
      start_val_s = WIDTH'(0);
    end
    if (wraps_r == 8'hFF) begin
      wraps_inc_s = 8'hFF;
    end else begin
      wraps_inc_s = wraps_r + 8'd1;
    end
  end

  // Run controller and counter state; all outputs come straight from these registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      count_r <= WIDTH'(0);
      tc_r    <= 1'b0;
      wraps_r <= 8'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          tc_r <= 1'b0;
          if (start) begin
            state_r <= RUN;
            count_r <= start_val_s;
            wraps_r <= 8'd0;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
          end
        end
        RUN: begin
          if (load) begin
            count_r <= clip_s;
            tc_r    <= 1'b0;
          end else if (en) begin
            count_r <= step_s;
            tc_r    <= wrap_s;
            if (wrap_s) begin
              wraps_r <= wraps_inc_s;
              $display("Wrap %0d count %0d", wraps_inc_s, step_s);
              if (wraps_inc_s == ROUNDS_C) begin
                state_r <= DONE;
                busy_r  <= 1'b0;
                done_r  <= 1'b1;
                $display("Run complete");
              end
            end
          end else begin
            tc_r <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          tc_r    <= 1'b0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign count = count_r;
  assign tc    = tc_r;
  assign wraps = wraps_r;
  assign busy  = busy_r;
  assign done  = done_r;

`ifdef PARAM_COUNTER_CHECK_EN
  param_counter_checker #(
    .WIDTH  (WIDTH),
    .LIMIT  (LIMIT),
    .ROUNDS (ROUNDS)
  ) u_checker (
    .clk   (clk),
    .rst_n (rst_n),
    .count (count_r),
    .tc    (tc_r),
    .wraps (wraps_r),
    .busy  (busy_r),
    .done  (done_r)
  );
`endif

endmodule

`ifdef PARAM_COUNTER_CHECK_EN
// Immediate invariants on the registered outputs, evaluated on every edge outside reset.
module param_counter_checker #(
  parameter int WIDTH  = 4,
  parameter int LIMIT  = 9,
  parameter int ROUNDS = 2
) (
  input logic             clk,
  input logic             rst_n,
  input logic [WIDTH-1:0] count,
  input logic             tc,
  input logic [7:0]       wraps,
  input logic             busy,
  input logic             done
);

  localparam logic [WIDTH-1:0] LIMIT_C  = WIDTH'(LIMIT);
  localparam logic [7:0]       ROUNDS_C = 8'(ROUNDS);

  // Invariants hold on every clock once out of reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (count <= LIMIT_C);
      assert (!(busy && done));
      assert (!tc || (wraps != 8'd0));
      assert (wraps <= ROUNDS_C);
    end
  end

endmodule
`endif
